// File: rtl/mmb_ram_slave_if.sv
// Burst MemoryMapped bus between a master and the RAM slave.
interface mmb_ram_slave_if #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned AWIDTH = 10,
    parameter int unsigned BWIDTH = 8
);
    logic [AWIDTH-1:0]   s_addr;
    logic [BWIDTH-1:0]   s_bcnt;
    logic                s_wreq;
    logic [DWIDTH-1:0]   s_wdat;
    logic [DWIDTH/8-1:0] s_bena;
    logic                s_rreq;
    logic [DWIDTH-1:0]   s_rdat;
    logic                s_rval;
    logic                s_busy;

    modport master (
        output s_addr, s_bcnt, s_wreq, s_wdat, s_bena, s_rreq,
        input  s_rdat, s_rval, s_busy
    );

    modport slave (
        input  s_addr, s_bcnt, s_wreq, s_wdat, s_bena, s_rreq,
        output s_rdat, s_rval, s_busy
    );
endinterface

// File: rtl/mmb_ram_slave.sv
// Burst MemoryMapped RAM slave: byte-enabled writes, queued burst reads with a
// fixed read pipeline, sticky protocol-error flags and optional random stalls.
module mmb_ram_slave #(
    parameter int unsigned DWIDTH   = 32,
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned BWIDTH   = 8,
    parameter int unsigned RDDELAY  = 2,
    parameter int unsigned RDPENDS  = 4,
    parameter bit          STALL_EN = 1'b0,
    parameter logic [15:0] SEED     = 16'hACE1
) (
    input  logic           clk,
    input  logic           reset,
    mmb_ram_slave_if.slave bus,
    input  logic           err_clr,
    output logic [2:0]     err_flags
);
    localparam int unsigned NB    = DWIDTH / 8;
    localparam int unsigned DEPTH = 1 << AWIDTH;
    localparam int unsigned PW    = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
    localparam int unsigned CW    = $clog2(RDPENDS + 1);
    localparam int unsigned CMDW  = AWIDTH + BWIDTH + DWIDTH + NB + 2;

    typedef enum logic {StIdle, StBurst} eng_state_e;

    logic [DWIDTH-1:0]        mem [DEPTH];

    // Pending-read FIFO
    logic [AWIDTH+BWIDTH-1:0] fifo_q [RDPENDS];
    logic [PW-1:0]            wptr_q, rptr_q;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [AWIDTH-1:0]        head_addr;
    logic [BWIDTH-1:0]        head_bcnt;

    // Write burst state: waddr_q is the address of the next beat
    logic                     wburst_q;
    logic [AWIDTH-1:0]        waddr_q, wr_addr;
    logic [BWIDTH-1:0]        wrem_q, wr_left;

    // Read engine
    eng_state_e               state_q, state_d;
    logic [AWIDTH-1:0]        cur_addr_q, iss_addr;
    logic [BWIDTH-1:0]        cur_left_q, iss_left;
    logic                     pop, issue;

    // Read pipeline; stage i holds a word issued i edges earlier
    logic [RDDELAY:0]         pv_q;
    logic [DWIDTH-1:0]        pd_q [RDDELAY+1];

    logic                     busy_q, busy_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic                     wr_acc, rd_acc;
    logic [2:0]               err_q, err_new;
    logic                     stall_q;
    logic [CMDW-1:0]          snap_q, cmd;

    // During a write burst a concurrent rreq is an error but does not block the beat
    assign wr_acc = bus.s_wreq & ~busy_q & (~bus.s_rreq | wburst_q);
    assign rd_acc = bus.s_rreq & ~busy_q & ~bus.s_wreq & ~wburst_q;

    assign {head_addr, head_bcnt} = fifo_q[rptr_q];
    assign wr_addr  = wburst_q ? waddr_q : bus.s_addr;
    assign wr_left  = (wburst_q ? wrem_q : bus.s_bcnt) - BWIDTH'(1);
    assign cmd      = {bus.s_addr, bus.s_bcnt, bus.s_wdat, bus.s_bena, bus.s_wreq, bus.s_rreq};
    assign cnt_d    = cnt_q + CW'(rd_acc) - CW'(pop);
    assign lfsr_d   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign busy_d   = (cnt_d >= CW'(RDPENDS)) | (STALL_EN & lfsr_q[0]);

    assign bus.s_busy = busy_q;
    assign bus.s_rval = pv_q[RDDELAY];
    assign bus.s_rdat = pd_q[RDDELAY];
    assign err_flags  = err_q;

    // RAM byte-lane writes; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (bus.s_bena[b]) mem[wr_addr][8*b +: 8] <= bus.s_wdat[8*b +: 8];
            end
        end
    end

    // FIFO storage; validity lives in the pointers
    always_ff @(posedge clk) begin
        if (rd_acc) fifo_q[wptr_q] <= {bus.s_addr, bus.s_bcnt};
    end

    // FIFO pointers, occupancy and registered back-pressure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            lfsr_q <= SEED;
        end else begin
            if (rd_acc) wptr_q <= (wptr_q == PW'(RDPENDS - 1)) ? '0 : wptr_q + PW'(1);
            if (pop)    rptr_q <= (rptr_q == PW'(RDPENDS - 1)) ? '0 : rptr_q + PW'(1);
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            lfsr_q <= lfsr_d;
        end
    end

    // Write burst tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wburst_q <= 1'b0;
            waddr_q  <= '0;
            wrem_q   <= '0;
        end else if (wr_acc) begin
            waddr_q  <= wr_addr + AWIDTH'(1);
            wrem_q   <= wr_left;
            wburst_q <= (wr_left != '0);
        end
    end

    // Read engine state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    // Read engine next state; an idle engine pops and issues on the same edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (pop && iss_left != '0) state_d = StBurst;
            StBurst: if (iss_left == '0) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read engine outputs: which word to issue this cycle
    always_comb begin
        pop      = 1'b0;
        issue    = 1'b0;
        iss_addr = cur_addr_q;
        iss_left = cur_left_q - BWIDTH'(1);
        case (state_q)
            StIdle: begin
                if (cnt_q != '0) begin
                    pop      = 1'b1;
                    issue    = 1'b1;
                    iss_addr = head_addr;
                    iss_left = head_bcnt - BWIDTH'(1);
                end
            end
            StBurst: issue = 1'b1;
            default: ;
        endcase
    end

    // Burst address and remaining-word count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_addr_q <= '0;
            cur_left_q <= '0;
        end else if (issue) begin
            cur_addr_q <= iss_addr + AWIDTH'(1);
            cur_left_q <= iss_left;
        end
    end

    // Read pipeline; data is forced to zero alongside an invalid stage
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pv_q <= '0;
            for (int i = 0; i <= int'(RDDELAY); i++) pd_q[i] <= '0;
        end else begin
            pv_q    <= {pv_q[RDDELAY-1:0], issue};
            pd_q[0] <= issue ? mem[iss_addr] : '0;
            for (int i = 1; i <= int'(RDDELAY); i++) pd_q[i] <= pd_q[i-1];
        end
    end

    // Error sources for this edge
    always_comb begin
        err_new    = '0;
        err_new[0] = bus.s_wreq & bus.s_rreq;
        err_new[1] = bus.s_rreq & wburst_q;
        err_new[2] = stall_q & (snap_q != cmd);
    end

    // Sticky error flags and stalled-command snapshot; a new error beats err_clr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q   <= '0;
            stall_q <= 1'b0;
            snap_q  <= '0;
        end else begin
            err_q   <= (err_clr ? 3'b000 : err_q) | err_new;
            stall_q <= (bus.s_wreq | bus.s_rreq) & busy_q;
            snap_q  <= cmd;
        end
    end
endmodule

// File: tb/tb_mmb_ram_slave.sv
// Bench for mmb_ram_slave: transaction-level model plus directed literal checks.
module tb_mmb_ram_slave;
    localparam int RD = 3;

    logic       clk;
    logic       reset;
    logic       err_clr;
    logic [2:0] err_flags;

    mmb_ram_slave_if #(.DWIDTH(32), .AWIDTH(10), .BWIDTH(4)) bus ();

    mmb_ram_slave #(
        .DWIDTH(32), .AWIDTH(10), .BWIDTH(4), .RDDELAY(RD), .RDPENDS(4),
        .STALL_EN(1'b0), .SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .err_clr(err_clr),
        .err_flags(err_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;
    int tb_cyc;
    int first_rval_cyc;
    logic [31:0] got[$];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, tb_cyc);
        end
    endfunction

    function automatic void fail_now(string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, tb_cyc);
    endfunction

    // ---------------- behavioural model ----------------
    typedef struct { int addr; int cnt; } rd_t;
    typedef struct { int due; logic [31:0] data; } exp_t;

    logic [31:0] m_mem [1024];
    rd_t         m_q[$];
    exp_t        exp_q[$];
    int          m_cur_addr, m_cur_left, m_waddr, m_wleft;
    bit          m_busy, m_stall;
    logic [2:0]  m_err;
    logic [51:0] m_snap;

    initial for (int i = 0; i < 1024; i++) m_mem[i] = '0;

    always @(posedge clk or posedge reset) begin : model
        bit          wa, ra, busy_pre;
        logic [2:0]  ne;
        logic [51:0] cmd;
        rd_t         r;
        tb_cyc++;
        if (reset) begin
            m_q.delete();
            exp_q.delete();
            m_cur_left = 0;
            m_wleft    = 0;
            m_busy     = 0;
            m_stall    = 0;
            m_err      = '0;
            m_snap     = '0;
        end else begin
            cmd = {bus.s_addr, bus.s_bcnt, bus.s_wdat, bus.s_bena, bus.s_wreq, bus.s_rreq};
            busy_pre = m_busy;
            ne[0] = bus.s_wreq & bus.s_rreq;
            ne[1] = bus.s_rreq & (m_wleft != 0);
            ne[2] = m_stall & (cmd != m_snap);
            m_err = (err_clr ? 3'b000 : m_err) | ne;
            wa = bus.s_wreq && !busy_pre && (!bus.s_rreq || m_wleft != 0);
            ra = bus.s_rreq && !bus.s_wreq && m_wleft == 0 && !busy_pre;
            if (m_cur_left == 0 && m_q.size() > 0) begin
                r = m_q.pop_front();
                m_cur_addr = r.addr;
                m_cur_left = r.cnt;
            end
            if (m_cur_left > 0) begin
                exp_q.push_back('{due: tb_cyc + RD, data: m_mem[m_cur_addr]});
                m_cur_addr = (m_cur_addr + 1) % 1024;
                m_cur_left--;
            end
            if (wa) begin
                if (m_wleft == 0) begin
                    m_waddr = int'(bus.s_addr);
                    m_wleft = (bus.s_bcnt == 0) ? 16 : int'(bus.s_bcnt);
                end
                for (int b = 0; b < 4; b++)
                    if (bus.s_bena[b]) m_mem[m_waddr][8*b +: 8] = bus.s_wdat[8*b +: 8];
                m_waddr = (m_waddr + 1) % 1024;
                m_wleft--;
            end
            if (ra) m_q.push_back('{addr: int'(bus.s_addr),
                                    cnt: (bus.s_bcnt == 0) ? 16 : int'(bus.s_bcnt)});
            m_busy  = m_q.size() >= 4;
            m_stall = (bus.s_wreq | bus.s_rreq) && busy_pre;
            m_snap  = cmd;
        end
    end

    // Per-cycle compare against the model, mid-cycle
    always @(negedge clk) begin : compare
        logic        ev;
        logic [31:0] ed;
        ev = 1'b0;
        ed = '0;
        if (!reset && exp_q.size() > 0 && exp_q[0].due == tb_cyc) begin
            ev = 1'b1;
            ed = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        chk("rval", 32'(bus.s_rval), 32'(ev));
        chk("rdat", bus.s_rdat, ed);
        chk("busy", 32'(bus.s_busy), 32'(m_busy));
        chk("err_flags", 32'(err_flags), 32'(m_err));
        if (bus.s_rval) begin
            got.push_back(bus.s_rdat);
            if (first_rval_cyc < 0) first_rval_cyc = tb_cyc;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.s_wreq = 1'b0;
        bus.s_rreq = 1'b0;
        err_clr    = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.s_busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now("ready_wait");
    endtask

    task automatic wr(input logic [9:0] a, input logic [3:0] c, input logic [31:0] d,
                      input logic [3:0] be);
        bus.s_addr = a; bus.s_bcnt = c; bus.s_wdat = d; bus.s_bena = be;
        bus.s_wreq = 1'b1; bus.s_rreq = 1'b0;
        wait_ready();
        tick();
    endtask

    task automatic rd(input logic [9:0] a, input logic [3:0] c);
        bus.s_addr = a; bus.s_bcnt = c;
        bus.s_wreq = 1'b0; bus.s_rreq = 1'b1;
        wait_ready();
        tick();
    endtask

    task automatic wait_got(input int n);
        int k = 0;
        while (got.size() < n && k < 400) begin
            tick();
            k++;
        end
        if (got.size() < n) fail_now("rval_wait");
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, stalls, k;
        n_cmp = 0; n_fail = 0; tb_cyc = 0; first_rval_cyc = -1;
        reset = 1'b1;
        bus.s_addr = '0; bus.s_bcnt = '0; bus.s_wdat = '0; bus.s_bena = '0;
        idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rval", 32'(bus.s_rval), 32'd0);
        chk("reset_rdat", bus.s_rdat, 32'd0);
        chk("reset_busy", 32'(bus.s_busy), 32'd0);
        chk("reset_err", 32'(err_flags), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        tick();

        // Preload 0x3F8..0x007 with a 16-beat (bcnt=0) write burst
        for (int i = 0; i < 16; i++) wr(10'h3F8, 4'd0, 32'h1000 + 32'(i), 4'hF);
        idle();
        tick();

        // Wrapping 4-word write then read
        for (int i = 0; i < 4; i++) wr(10'h3FE, 4'd4, 32'(i + 1), 4'hF);
        got.delete();
        rd(10'h3FE, 4'd4);
        idle();
        wait_got(4);
        for (int i = 0; i < 4; i++) chk("wrap_read", got[i], 32'(i + 1));

        // Byte enables
        wr(10'h010, 4'd1, 32'hFFFF_FFFF, 4'hF);
        wr(10'h010, 4'd1, 32'h0000_0000, 4'b0101);
        got.delete();
        rd(10'h010, 4'd1);
        idle();
        wait_got(1);
        chk("bena_merge", got[0], 32'hFF00_FF00);

        // Latency and a 16-word (bcnt=0) read burst
        got.delete();
        first_rval_cyc = -1;
        rd(10'h3F8, 4'd0);
        acc = tb_cyc;
        idle();
        wait_got(16);
        repeat (10) tick();
        chk("first_latency", 32'(first_rval_cyc - acc), 32'd4);
        chk("burst16_count", 32'(got.size()), 32'd16);
        chk("burst16_first", got[0], 32'h0000_1000);
        chk("burst16_last", got[15], 32'h0000_100F);

        // FIFO full: engine busy on a 16-word burst, four 1-word reads queue up
        got.delete();
        rd(10'h3F8, 4'd0);
        rd(10'h3FE, 4'd1);
        rd(10'h3FF, 4'd1);
        rd(10'h000, 4'd1);
        rd(10'h001, 4'd1);
        chk("busy_after_4", 32'(bus.s_busy), 32'd1);
        bus.s_addr = 10'h010; bus.s_bcnt = 4'd1; bus.s_rreq = 1'b1;
        stalls = 0;
        while (bus.s_busy && stalls < 200) begin
            tick();
            stalls++;
        end
        tick();
        idle();
        chk("fifth_held", 32'(stalls > 0), 32'd1);
        wait_got(21);
        chk("q_rd1", got[16], 32'd1);
        chk("q_rd2", got[17], 32'd2);
        chk("q_rd3", got[18], 32'd3);
        chk("q_rd4", got[19], 32'd4);
        chk("q_rd5", got[20], 32'hFF00_FF00);

        // wreq and rreq together
        bus.s_addr = 10'h030; bus.s_bcnt = 4'd1; bus.s_wdat = 32'hDEAD_BEEF;
        bus.s_bena = 4'hF; bus.s_wreq = 1'b1; bus.s_rreq = 1'b1;
        tick();
        idle();
        chk("err_both", 32'(err_flags), 32'b001);
        clear_err();
        chk("err_clr_a", 32'(err_flags), 32'd0);

        // rreq inside a 3-beat write burst
        wr(10'h020, 4'd3, 32'hA1A1_A1A1, 4'hF);
        bus.s_wreq = 1'b0; bus.s_rreq = 1'b1;
        tick();
        wr(10'h020, 4'd3, 32'hA2A2_A2A2, 4'hF);
        wr(10'h020, 4'd3, 32'hA3A3_A3A3, 4'hF);
        idle();
        chk("err_rd_in_wr", 32'(err_flags), 32'b010);
        clear_err();
        chk("err_clr_b", 32'(err_flags), 32'd0);
        got.delete();
        rd(10'h020, 4'd3);
        idle();
        wait_got(3);
        chk("wburst_b0", got[0], 32'hA1A1_A1A1);
        chk("wburst_b1", got[1], 32'hA2A2_A2A2);
        chk("wburst_b2", got[2], 32'hA3A3_A3A3);

        // Command changed while a write is stalled behind a full FIFO
        got.delete();
        rd(10'h3F8, 4'd0);
        rd(10'h3FE, 4'd1);
        rd(10'h3FF, 4'd1);
        rd(10'h000, 4'd1);
        rd(10'h001, 4'd1);
        bus.s_addr = 10'h030; bus.s_bcnt = 4'd1; bus.s_wdat = 32'h1111_1111;
        bus.s_bena = 4'hF; bus.s_wreq = 1'b1; bus.s_rreq = 1'b0;
        tick();
        bus.s_wdat = 32'h2222_2222;
        tick();
        chk("err_changed", 32'(err_flags), 32'b100);
        wait_ready();
        tick();
        idle();
        wait_got(20);
        clear_err();
        chk("err_clr_c", 32'(err_flags), 32'd0);

        // Reset in the middle of an 8-word read
        got.delete();
        rd(10'h3FE, 4'd8);
        idle();
        k = 0;
        while (got.size() < 3 && k < 100) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (got.size() < 3) fail_now("rst_wait");
        reset = 1'b1;
        #1;
        chk("rst_rval_now", 32'(bus.s_rval), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) tick();
        chk("rst_no_more", 32'(got.size()), 32'd3);
        got.delete();
        rd(10'h3FE, 4'd4);
        idle();
        wait_got(4);
        for (int i = 0; i < 4; i++) chk("ram_kept", got[i], 32'(i + 1));

        repeat (5) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
